// File: rtl/sccpu_store_buffer_pkg.sv
// Shared constants and types for the single-cycle CPU store buffer.
// Default geometry, FIFO operation encoding and the occupancy-width helper.
package sccpu_store_buffer_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 32;
    localparam int unsigned SB_DW    = 32;

    // Bit 1 = enqueue, bit 0 = dequeue, so {enq, deq} casts directly.
    typedef enum logic [1:0] {
        SB_IDLE = 2'b00,
        SB_DEQ  = 2'b01,
        SB_ENQ  = 2'b10,
        SB_BOTH = 2'b11
    } sb_op_e;

    function automatic int unsigned sb_count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sccpu_store_buffer_if.sv
// CPU data port, RAM port and status signals of the store buffer.
// The slave modport is the buffer itself; master is the CPU/RAM environment.
interface sccpu_store_buffer_if
    import sccpu_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
);
    localparam int unsigned CW = sb_count_width(DEPTH);

    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_wmem;
    logic [DW-1:0] cpu_rdata;
    logic          stall;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ready;
    logic          empty;
    logic [CW-1:0] count;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wmem, ram_rdata, ram_ready,
        output cpu_rdata, stall, ram_raddr, ram_we, ram_waddr, ram_wdata, empty, count
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_wmem, ram_rdata, ram_ready,
        input  cpu_rdata, stall, ram_raddr, ram_we, ram_waddr, ram_wdata, empty, count
    );

endinterface

// File: rtl/sccpu_store_buffer_fwd_match.sv
// Load-forwarding lookup: finds the youngest valid entry whose word address
// matches the lookup address, age measured backwards from the write pointer.
module sccpu_store_buffer_fwd_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WAW   = 30
) (
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [WAW-1:0]           addr_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] wr_ptr_i,
    input  logic [WAW-1:0]           lookup_i,
    output logic                     hit_o,
    output logic [$clog2(DEPTH)-1:0] sel_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] by_age;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = valid_i[i] && (addr_i[i] == lookup_i);
        end
        // Rotate so bit k is the entry k+1 slots behind wr_ptr: bit 0 is youngest.
        for (int unsigned k = 0; k < DEPTH; k++) begin
            by_age[k] = match[wr_ptr_i - PW'(k + 1)];
        end
        hit_o = |by_age;
        sel_o = '0;
        for (int unsigned k = DEPTH; k > 0; k--) begin
            if (by_age[k-1]) begin
                sel_o = wr_ptr_i - PW'(k);
            end
        end
    end

endmodule

// File: rtl/sccpu_store_buffer.sv
// Posted-write store buffer between the CPU data port and the data RAM:
// in-order drain, youngest-entry load forwarding, stall when full.
module sccpu_store_buffer
    import sccpu_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic                clock,
    input  logic                reset,
    sccpu_store_buffer_if.slave sb
);
    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam int unsigned   CW   = sb_count_width(DEPTH);
    localparam int unsigned   WAW  = AW - 2;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WAW-1:0]   addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             enq;
    logic             deq;
    sb_op_e           op;
    logic             hit;
    logic [PW-1:0]    hit_idx;

    assign enq = sb.cpu_wmem && (count_q != FULL);
    assign deq = (count_q != '0) && sb.ram_ready;
    assign op  = sb_op_e'({enq, deq});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (deq) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (enq) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        unique case (op)
            SB_ENQ:  count_d = count_q + 1'b1;
            SB_DEQ:  count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Payload storage carries no reset; valid_q/count_q decide what is live.
    always_ff @(posedge clock) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= sb.cpu_addr[AW-1:2];
            data_q[wr_ptr_q] <= sb.cpu_wdata;
        end
    end

    sccpu_store_buffer_fwd_match #(
        .DEPTH (DEPTH),
        .WAW   (WAW)
    ) u_fwd_match (
        .valid_i  (valid_q),
        .addr_i   (addr_q),
        .wr_ptr_i (wr_ptr_q),
        .lookup_i (sb.cpu_addr[AW-1:2]),
        .hit_o    (hit),
        .sel_o    (hit_idx)
    );

    always_comb begin
        sb.ram_raddr = sb.cpu_addr;
        sb.ram_we    = (count_q != '0);
        sb.ram_waddr = {addr_q[rd_ptr_q], 2'b00};
        sb.ram_wdata = data_q[rd_ptr_q];
        sb.empty     = (count_q == '0);
        sb.count     = count_q;
        sb.stall     = sb.cpu_wmem && (count_q == FULL);
        sb.cpu_rdata = hit ? data_q[hit_idx] : sb.ram_rdata;
    end

endmodule

// File: tb/tb_sccpu_store_buffer.sv
// Scoreboard bench for the store buffer: a queue-based memory-order model
// predicts outputs and RAM writes; a negedge monitor pops and compares.
module tb_sccpu_store_buffer;
    import sccpu_store_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sccpu_store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    sccpu_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .sb    (bus)
    );

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic [CW-1:0] count;
        logic          empty;
        logic          stall;
        logic          we;
        logic [31:0]   raddr;
        logic [31:0]   waddr;
        logic [31:0]   wdata;
        logic          ld;
        logic [31:0]   rdata;
    } exp_t;

    ent_t mdl[$];      // buffered stores, oldest first
    ent_t wr_exp[$];   // RAM writes expected, in order
    exp_t exp_q[$];    // per-cycle combinational expectations

    int checks = 0;
    int errors = 0;

    exp_t me;
    ent_t mw;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // One CPU cycle: drive inputs, predict outputs, advance the model at the edge.
    task automatic step(input logic wmem, input logic [31:0] addr, input logic [31:0] data,
                        input logic ready, input logic [31:0] rdata);
        exp_t e;
        ent_t ne;
        bit   acc_enq;
        bit   acc_deq;
        bus.cpu_wmem  = wmem;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = data;
        bus.ram_ready = ready;
        bus.ram_rdata = rdata;
        acc_deq  = (mdl.size() != 0) && ready;
        acc_enq  = wmem && (mdl.size() < DEPTH);
        e.count  = CW'(mdl.size());
        e.empty  = (mdl.size() == 0);
        e.stall  = wmem && (mdl.size() == DEPTH);
        e.we     = (mdl.size() != 0);
        e.raddr  = addr;
        e.ld     = !wmem;
        e.rdata  = rdata;
        e.waddr  = '0;
        e.wdata  = '0;
        if (mdl.size() != 0) begin
            e.waddr = {mdl[0].w, 2'b00};
            e.wdata = mdl[0].d;
        end
        for (int i = mdl.size() - 1; i >= 0; i--) begin
            if (mdl[i].w == addr[31:2]) begin
                e.rdata = mdl[i].d;
                break;
            end
        end
        exp_q.push_back(e);
        if (acc_deq) wr_exp.push_back(mdl[0]);
        @(posedge clock);
        if (acc_deq) void'(mdl.pop_front());
        if (acc_enq) begin
            ne.w = addr[31:2];
            ne.d = data;
            mdl.push_back(ne);
        end
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && mdl.size() != 0; n++) begin
            step(1'b0, 32'h0000_0400, 32'h0, 1'b1, $urandom);
        end
        chk("drain_to_empty", mdl.size(), 0);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            me = exp_q.pop_front();
            chk("count", bus.count, me.count);
            chk("empty", bus.empty, me.empty);
            chk("stall", bus.stall, me.stall);
            chk("ram_we", bus.ram_we, me.we);
            chk("ram_raddr", bus.ram_raddr, me.raddr);
            if (me.we) begin
                chk("ram_waddr_head", bus.ram_waddr, me.waddr);
                chk("ram_wdata_head", bus.ram_wdata, me.wdata);
            end
            if (me.ld) chk("cpu_rdata", bus.cpu_rdata, me.rdata);
        end
        if (reset && bus.ram_we && bus.ram_ready) begin
            if (wr_exp.size() != 0) begin
                mw = wr_exp.pop_front();
                chk("ram_write_addr", bus.ram_waddr, {mw.w, 2'b00});
                chk("ram_write_data", bus.ram_wdata, mw.d);
            end else begin
                checks++;
                errors++;
                $display("FAIL unexpected_ram_write actual=%h required=none", bus.ram_waddr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cpu_wmem  = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.ram_ready = 1'b0;
        bus.ram_rdata = 32'h5A5A_5A5A;
        #1;
        chk("reset_count", bus.count, 0);
        chk("reset_empty", bus.empty, 1);
        chk("reset_ram_we", bus.ram_we, 0);
        chk("reset_stall", bus.stall, 0);
        chk("reset_cpu_rdata", bus.cpu_rdata, 32'h5A5A_5A5A);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Single store held by RAM, then forwarded to a load.
        step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
        step(1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
        chk("fwd_single", bus.cpu_rdata, 32'hDEAD_BEEF);
        drain();

        // Two stores to one address: youngest forwards, both reach RAM in order.
        step(1'b1, 32'h20, 32'h1, 1'b0, 32'h0);
        step(1'b1, 32'h20, 32'h2, 1'b0, 32'h0);
        step(1'b0, 32'h20, 32'h0, 1'b0, 32'hFFFF_FFFF);
        chk("fwd_youngest", bus.cpu_rdata, 32'h2);
        step(1'b0, 32'h20, 32'h0, 1'b1, 32'h0);
        step(1'b0, 32'h20, 32'h0, 1'b1, 32'h0);
        step(1'b0, 32'h20, 32'h0, 1'b0, 32'h0);

        // Fill to capacity, stall, drain one with stall still held, retry, wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 32'h100 + 32'(i), 1'b0, 32'h0);
        step(1'b1, 32'h30, 32'h3030, 1'b0, 32'h0);
        step(1'b1, 32'h30, 32'h3030, 1'b1, 32'h0);
        step(1'b1, 32'h30, 32'h3030, 1'b0, 32'h0);
        step(1'b0, 32'h31, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'h8, 32'h0, 1'b0, 32'h0);
        drain();

        // Steady enqueue+dequeue keeps occupancy flat.
        step(1'b1, 32'h50, 32'hA, 1'b0, 32'h0);
        step(1'b1, 32'h54, 32'hB, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h58 + 32'(i * 4), 32'hC0 + 32'(i), 1'b1, 32'h0);
        drain();

        // Load miss returns RAM data.
        step(1'b1, 32'h44, 32'h77, 1'b0, 32'h0);
        step(1'b0, 32'h40, 32'h0, 1'b0, 32'h1234_5678);

        // Asynchronous reset mid-drain discards buffered stores.
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(i * 4), 32'hBB00 + 32'(i), 1'b0, 32'h0);
        step(1'b0, 32'h104, 32'h0, 1'b1, 32'h0);
        bus.cpu_wmem  = 1'b0;
        bus.ram_rdata = 32'hCAFE_0000;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_count", bus.count, 0);
        chk("async_rst_empty", bus.empty, 1);
        chk("async_rst_ram_we", bus.ram_we, 0);
        chk("async_rst_cpu_rdata", bus.cpu_rdata, 32'hCAFE_0000);
        mdl.delete();
        wr_exp.delete();
        @(posedge clock);
        #1 reset = 1'b1;
        step(1'b0, 32'h104, 32'h0, 1'b0, 32'hCAFE_0001);

        // Randomised traffic over a small address window to exercise hits.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)),
                 32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                 $urandom, 1'($urandom_range(0, 1)), $urandom);
        end
        drain();
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clock);
        chk("pending_ram_writes", wr_exp.size(), 0);
        chk("pending_expectations", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
